mux_serializer: RTL

MUX_SERIALIZER -- requirements
Module: mux_serializer

---
 rtl/mux_serializer_pkg.sv | 12 +
 rtl/mux_serializer_mux8_sel.sv | 15 +
 rtl/mux_serializer.sv | 105 ++++++++++
 3 files changed

// File: rtl/mux_serializer_pkg.sv
// Shared constants and FSM encoding for the mux serializer.
package mux_serializer_pkg;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : mux_serializer_pkg

// File: rtl/mux_serializer_mux8_sel.sv
// Combinational 8:1 bit selector driven by the serializer's select code.
module mux8_sel
    import mux_serializer_pkg::*;
(
    input  logic [SEL_W-1:0]  select,
    input  logic [WORD_W-1:0] hold,
    output logic              q
);

    // Route the indexed bit of the holding register to q.
    always_comb begin
        q = hold[select];
    end

endmodule : mux8_sel

// File: rtl/mux_serializer.sv
// Parallel-to-serial converter: captures an 8-bit word and walks an 8:1 mux
// select code across it, holding each bit for DIV clock cycles.
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned DIV       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SEL_W-1:0]  select,
    output logic              q,
    output logic              q_valid,
    output logic              first,
    output logic              done
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] FIRST_SEL = MSB_FIRST ? SEL_W'(WORD_W - 1) : SEL_W'(0);
    localparam logic [SEL_W-1:0] LAST_SEL  = MSB_FIRST ? SEL_W'(0) : SEL_W'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              mux_bit;

    // State, holding register, select and divider registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: accept in IDLE, step select every DIV cycles in SHIFT.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    hold_d  = in_data;
                    sel_d   = FIRST_SEL;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sel_q == LAST_SEL) begin
                        // Park select at 0 so IDLE presents a clean code.
                        state_d = IDLE;
                        sel_d   = '0;
                        done_d  = 1'b1;
                    end else if (MSB_FIRST) begin
                        sel_d = sel_q - SEL_W'(1);
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mux8_sel u_mux (
        .select (sel_q),
        .hold   (hold_q),
        .q      (mux_bit)
    );

    // Outputs decoded from registered state only.
    always_comb begin
        in_ready = (state_q == IDLE);
        q_valid  = (state_q == SHIFT);
        select   = sel_q;
        q        = (state_q == SHIFT) & mux_bit;
        first    = (state_q == SHIFT) && (sel_q == FIRST_SEL);
        done     = done_q;
    end

endmodule : mux_serializer
